// File: rtl/subcarrier_map_pkg.sv
// Shared constants and types for the 802.11a/g subcarrier mapper.
// Bin classes are held as 64-bit masks indexed by IFFT bin number.
package subcarrier_map_pkg;

  localparam int NFFT  = 64;
  localparam int BIN_W = 6;
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NFFT - 1);

  // Pilot-polarity scrambler state loaded at each frame start
  localparam logic [6:0] DEFAULT_LFSR_SEED = 7'h7F;

  // NULL bins: DC (0) and the guard band 27..37
  localparam logic [NFFT-1:0] NULL_MASK      = 64'h0000_003F_F800_0001;
  // PILOT bins: 7, 21, 43, 57
  localparam logic [NFFT-1:0] PILOT_MASK     = 64'h0200_0800_0020_0080;
  // Base pilot signs: only bin 21 is -1, the other pilots are +1
  localparam logic [NFFT-1:0] PILOT_NEG_MASK = 64'h0000_0000_0020_0000;

  typedef enum logic [1:0] {
    BIN_NULL,
    BIN_PILOT,
    BIN_DATA
  } bin_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP,
    ST_FLUSH,
    ST_CLOSE
  } state_t;

  function automatic bin_class_t classify(input logic [BIN_W-1:0] k);
    bin_class_t c;
    if (NULL_MASK[k])       c = BIN_NULL;
    else if (PILOT_MASK[k]) c = BIN_PILOT;
    else                    c = BIN_DATA;
    return c;
  endfunction

  function automatic logic pilot_base_neg(input logic [BIN_W-1:0] k);
    return PILOT_NEG_MASK[k];
  endfunction

endpackage

// File: rtl/subcarrier_map_pilot_lfsr.sv
// Pilot-polarity scrambler, x^7 + x^4 + 1. The output bit is the
// feedback of the current state: 0 selects +1 polarity, 1 selects -1.
module pilot_lfsr #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic pol_neg
);

  logic [6:0] s;
  logic       fb;

  assign fb      = s[6] ^ s[3];
  assign pol_neg = fb;

  // Reload at frame start, step once per completed symbol
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          s <= SEED;
    else if (load)    s <= SEED;
    else if (advance) s <= {s[5:0], fb};
  end

endmodule

// File: rtl/subcarrier_map.sv
// 802.11a/g subcarrier mapper: 48 data words in, 64 IFFT bins out per
// symbol, with DC/guard nulls and four BPSK pilots inserted.
// Build option SCRAMBLED_PILOT_EN: when defined, pilot polarity follows the
// 127-long scrambler; when undefined, pilots always use the base pattern.
module subcarrier_map
  import subcarrier_map_pkg::*;
#(
  parameter logic signed [15:0] PILOT_AMP = 16'sd8192,
  parameter logic [6:0]         LFSR_SEED = DEFAULT_LFSR_SEED
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  state_t           state, state_n;
  logic [BIN_W-1:0] bin, bin_n;
  bin_class_t       cls;
  logic             ena;
  logic             out_halt;
  logic             cyc_prev;
  logic [31:0]      dat_n;
  logic [31:0]      bin_word;
  logic             stb_n;
  logic             cyc_n;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             pol_neg;

  function automatic logic [31:0] pilot_word(input logic neg);
    logic signed [15:0] i_val;
    i_val = neg ? -PILOT_AMP : PILOT_AMP;
    return {i_val, 16'h0000};
  endfunction

  assign ena      = CYC_I & STB_I & WE_I;
  assign out_halt = STB_O & ~ACK_I;
  assign cls      = classify(bin);
  assign ACK_O    = ~out_halt & ena & (state == ST_MAP) & (cls == BIN_DATA);
  assign WE_O     = STB_O;

  // Generated word for non-data bins; DATA bins map to zero during flush
  assign bin_word = (cls == BIN_PILOT) ? pilot_word(pilot_base_neg(bin) ^ pol_neg) : 32'h0;

`ifdef SCRAMBLED_PILOT_EN
  pilot_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_pilot_lfsr (
    .clk     (CLK_I),
    .rst     (RST_I),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .pol_neg (pol_neg)
  );
`else
  // Fixed +1 polarity; the scrambler controls and seed fold into a constant
  assign pol_neg = 1'b0 & (^{LFSR_SEED, lfsr_load, lfsr_adv});
`endif

  // Next-state, bin walk and output-register load decisions
  always_comb begin
    state_n   = state;
    bin_n     = bin;
    dat_n     = DAT_O;
    stb_n     = STB_O;
    cyc_n     = CYC_O;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (CYC_I && !cyc_prev) begin
          cyc_n     = 1'b1;
          lfsr_load = 1'b1;
          bin_n     = '0;
          state_n   = ST_MAP;
        end
      end
      ST_MAP: begin
        if (!out_halt) begin
          stb_n = 1'b0;
          if (bin == '0) begin
            // A symbol only starts once input data is actually on offer
            if (!CYC_I) begin
              state_n = ST_CLOSE;
            end else if (ena) begin
              stb_n = 1'b1;
              dat_n = 32'h0;
              bin_n = bin + 6'd1;
            end
          end else begin
            if (cls != BIN_DATA) begin
              stb_n    = 1'b1;
              dat_n    = bin_word;
              bin_n    = bin + 6'd1;
              lfsr_adv = (bin == BIN_LAST);
            end else if (ena) begin
              stb_n    = 1'b1;
              dat_n    = DAT_I;
              bin_n    = bin + 6'd1;
              lfsr_adv = (bin == BIN_LAST);
            end
            if (!CYC_I) state_n = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (!out_halt) begin
          stb_n = 1'b1;
          dat_n = bin_word;
          bin_n = bin + 6'd1;
          if (bin == BIN_LAST) begin
            lfsr_adv = 1'b1;
            state_n  = ST_CLOSE;
          end
        end
      end
      ST_CLOSE: begin
        // Drop the frame once the last word is gone
        if (!out_halt) begin
          stb_n   = 1'b0;
          cyc_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, bin counter and registered output stage
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      bin      <= '0;
      DAT_O    <= 32'h0;
      STB_O    <= 1'b0;
      CYC_O    <= 1'b0;
      cyc_prev <= 1'b0;
    end else begin
      state    <= state_n;
      bin      <= bin_n;
      DAT_O    <= dat_n;
      STB_O    <= stb_n;
      CYC_O    <= cyc_n;
      cyc_prev <= CYC_I;
    end
  end

endmodule

// File: tb/tb_subcarrier_map.sv
// Directed bench for subcarrier_map: expected bins are queued as frames are
// planned, accepted output words are captured and compared in order.
module tb_subcarrier_map;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] obs[$];
  logic [31:0] exp_q[$];
  int          obs_rd = 0;
  logic [7:0]  pol_neg_tab;

  subcarrier_map dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
    .ACK_I (ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Capture every word the downstream side accepts
  always @(negedge CLK_I) begin
    if (STB_O === 1'b1 && ACK_I === 1'b1) obs.push_back(DAT_O);
  end

  // Hard stop if something wedges beyond every bounded wait
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit is_null(input int k);
    return (k == 0) || (k >= 27 && k <= 37);
  endfunction

  function automatic bit is_pilot(input int k);
    return (k == 7) || (k == 21) || (k == 43) || (k == 57);
  endfunction

  function automatic logic [31:0] word_of(input int n);
    logic [15:0] i_part;
    logic [15:0] q_part;
    i_part = 16'(n);
    q_part = (n > 48) ? 16'(-n) : 16'h0000;
    return {i_part, q_part};
  endfunction

  task automatic push_symbol(input int sym, input int base, input int nvalid, input int nbins);
    int j;
    j = 0;
    for (int k = 0; k < nbins; k++) begin
      if (is_null(k)) begin
        exp_q.push_back(32'h0);
      end else if (is_pilot(k)) begin
        if ((k == 21) ^ pol_neg_tab[sym]) exp_q.push_back(32'hE000_0000);
        else                              exp_q.push_back(32'h2000_0000);
      end else begin
        exp_q.push_back((j < nvalid) ? word_of(base + j) : 32'h0);
        j++;
      end
    end
  endtask

  task automatic check_obs(input string tag);
    logic [31:0] e;
    int guard;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (obs.size() <= obs_rd && guard < 400) begin
        @(posedge CLK_I); #1;
        guard++;
      end
      e = exp_q.pop_front();
      total++;
      assert (obs.size() > obs_rd) else begin
        bad++;
        $error("FAIL %s_present observed_count=%0d expected_count=%0d", tag, obs.size(), obs_rd + 1);
      end
      if (obs.size() > obs_rd) begin
        total++;
        assert (obs[obs_rd] === e) else begin
          bad++;
          $error("FAIL %s_bin%0d observed=%h expected=%h", tag, n, obs[obs_rd], e);
        end
        obs_rd++;
      end else begin
        exp_q.delete();
      end
      n++;
    end
  endtask

  task automatic wait_close(input string tag);
    int guard;
    guard = 0;
    while (CYC_O !== 1'b0 && guard < 600) begin
      @(posedge CLK_I); #1;
      guard++;
    end
    total++;
    assert (CYC_O === 1'b0) else begin
      bad++;
      $error("FAIL %s_cyc_o observed=%b expected=0", tag, CYC_O);
    end
    repeat (2) @(posedge CLK_I);
    #1;
    total++;
    assert (obs.size() === obs_rd) else begin
      bad++;
      $error("FAIL %s_extra observed_count=%0d expected_count=%0d", tag, obs.size(), obs_rd);
    end
  endtask

  task automatic drive_word(input logic [31:0] d);
    logic acc;
    int guard;
    DAT_I = d;
    STB_I = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (acc !== 1'b1 && guard < 200) begin
      @(negedge CLK_I);
      acc = ACK_O;
      @(posedge CLK_I); #1;
      guard++;
    end
    total++;
    assert (acc === 1'b1) else begin
      bad++;
      $error("FAIL ack_wait observed=%b expected=1", acc);
    end
  endtask

  task automatic send_frame(input int base, input int nwords, input int bubble_at, input bit close);
    CYC_I = 1'b1;
    WE_I  = 1'b1;
    for (int j = 0; j < nwords; j++) begin
      if (j == bubble_at) begin
        STB_I = 1'b0;
        for (int b = 0; b < 4; b++) begin
          @(posedge CLK_I); #1;
          total++;
          assert (STB_O === 1'b0) else begin
            bad++;
            $error("FAIL bubble_stb%0d observed=%b expected=0", b, STB_O);
          end
        end
      end
      drive_word(word_of(base + j));
    end
    STB_I = 1'b0;
    if (close) begin
      CYC_I = 1'b0;
      WE_I  = 1'b0;
    end
  endtask

  task automatic stall_at_bin7(input int start);
    int guard;
    guard = 0;
    while (!(STB_O === 1'b1 && obs.size() == start + 7) && guard < 300) begin
      @(posedge CLK_I); #1;
      guard++;
    end
    total++;
    assert (STB_O === 1'b1 && obs.size() == start + 7) else begin
      bad++;
      $error("FAIL stall_reach observed_count=%0d expected_count=%0d", obs.size(), start + 7);
    end
    ACK_I = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_I);
      total++;
      assert (DAT_O === 32'h2000_0000) else begin
        bad++;
        $error("FAIL stall_dat%0d observed=%h expected=%h", c, DAT_O, 32'h2000_0000);
      end
      total++;
      assert (ACK_O === 1'b0) else begin
        bad++;
        $error("FAIL stall_ack%0d observed=%b expected=0", c, ACK_O);
      end
      total++;
      assert (WE_O === 1'b1) else begin
        bad++;
        $error("FAIL stall_we%0d observed=%b expected=1", c, WE_O);
      end
      @(posedge CLK_I);
    end
    #1;
    ACK_I = 1'b1;
  endtask

  initial begin
    int start;
`ifdef SCRAMBLED_PILOT_EN
    pol_neg_tab = 8'b0111_0000;
`else
    pol_neg_tab = 8'b0000_0000;
`endif
    RST_I = 1'b1;
    DAT_I = 32'h0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ACK_I = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK_I);
    #1;
    total++;
    assert (DAT_O === 32'h0) else begin bad++; $error("FAIL rst_dat observed=%h expected=0", DAT_O); end
    total++;
    assert (STB_O === 1'b0) else begin bad++; $error("FAIL rst_stb observed=%b expected=0", STB_O); end
    total++;
    assert (CYC_O === 1'b0) else begin bad++; $error("FAIL rst_cyc observed=%b expected=0", CYC_O); end
    total++;
    assert (ACK_O === 1'b0) else begin bad++; $error("FAIL rst_ack observed=%b expected=0", ACK_O); end
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;

    // Single symbol, words 0x0001_0000 .. 0x0030_0000
    push_symbol(0, 1, 48, 64);
    send_frame(1, 48, -1, 1'b1);
    total++;
    assert (CYC_O === 1'b1) else begin bad++; $error("FAIL single_cyc_held observed=%b expected=1", CYC_O); end
    check_obs("single");
    wait_close("single");

    // Five back-to-back symbols exercise the pilot polarity sequence
    for (int s = 0; s < 5; s++) push_symbol(s, 100 + 48 * s, 48, 64);
    send_frame(100, 240, -1, 1'b1);
    check_obs("polarity");
    wait_close("polarity");

    // Downstream stall while bin 7 is presented
    push_symbol(0, 400, 48, 64);
    start = obs.size();
    fork
      send_frame(400, 48, -1, 1'b1);
      stall_at_bin7(start);
    join
    check_obs("backpressure");
    wait_close("backpressure");

    // Input bubble of four cycles at bin 10
    push_symbol(0, 700, 48, 64);
    send_frame(700, 48, 8, 1'b1);
    check_obs("bubble");
    wait_close("bubble");

    // Frame ends after 20 data words; remainder flushes with zeros
    push_symbol(0, 800, 20, 64);
    send_frame(800, 20, -1, 1'b1);
    check_obs("early_drop");
    wait_close("early_drop");

    // Asynchronous reset part-way through the guard band
    push_symbol(0, 500, 24, 27);
    send_frame(500, 24, -1, 1'b0);
    check_obs("pre_reset");
    repeat (3) @(posedge CLK_I);
    #3;
    RST_I = 1'b1;
    #1;
    total++;
    assert (DAT_O === 32'h0) else begin bad++; $error("FAIL arst_dat observed=%h expected=0", DAT_O); end
    total++;
    assert (STB_O === 1'b0) else begin bad++; $error("FAIL arst_stb observed=%b expected=0", STB_O); end
    total++;
    assert (CYC_O === 1'b0) else begin bad++; $error("FAIL arst_cyc observed=%b expected=0", CYC_O); end
    total++;
    assert (ACK_O === 1'b0) else begin bad++; $error("FAIL arst_ack observed=%b expected=0", ACK_O); end
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    obs_rd = obs.size();
    @(posedge CLK_I); #1;

    // Fresh frame after reset starts from bin 0 with base pilots
    push_symbol(0, 600, 48, 64);
    send_frame(600, 48, -1, 1'b1);
    check_obs("post_reset");
    wait_close("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
